// File: rtl/booth_mult_pkg.sv
// Shared definitions for the pipelined radix-4 Booth multiplier.
//   npp(width)          number of Booth partial products for a width
//   ksa_idx(width)      log2 of the power-of-two adder width
//   prod_w(width)       full product width
//   csa_* helpers       row counts for the 3:2 reduction tree
//   booth_digit_e       recoded digit, plus booth_decode() for a 3-bit window
package booth_mult_pkg;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_digit_e;

  function automatic int npp(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int ksa_idx(input int width);
    return $clog2(2 * width);
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // One 3:2 level turns every full group of three rows into two and passes
  // the leftovers through.
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int csa_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) r = csa_next(r);
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int k = 0; k < 64; k++) begin
      if (r > 2) begin
        r = csa_next(r);
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}; 111 is treated as a plain zero.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return P1;
      3'b011:         return P2;
      3'b100:         return M2;
      3'b101, 3'b110: return M1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product selector.
//   win_i  3-bit recoding window of the multiplier
//   a_i    multiplicand
//   pp_o   magnitude (a or 2a), bitwise inverted when the digit is negative
//   neg_o  1 for a negative digit; the +1 that completes the negation is
//          added later as a separate row
module booth_pp_gen
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [2:0]       win_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH:0]   pp_o,
  output logic             neg_o
);

  booth_digit_e   digit;
  logic [WIDTH:0] mag;

  always_comb begin
    digit = booth_decode(win_i);
    mag   = '0;
    neg_o = 1'b0;
    case (digit)
      P1: mag = {1'b0, a_i};
      P2: mag = {a_i, 1'b0};
      M1: begin
        mag   = {1'b0, a_i};
        neg_o = 1'b1;
      end
      M2: begin
        mag   = {a_i, 1'b0};
        neg_o = 1'b1;
      end
      default: mag = '0;
    endcase
    pp_o = neg_o ? ~mag : mag;
  end

endmodule

// File: rtl/ksa_adder.sv
// Kogge-Stone parallel-prefix adder, width 2**IDX, no carry in/out.
//   x_i, y_i  addends
//   sum_o     x_i + y_i modulo 2**IDX
module ksa_adder #(
  parameter int IDX = 4,
  localparam int W  = 1 << IDX
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] sum_o
);

  logic [IDX:0][W-1:0] gen;
  logic [IDX:0][W-1:0] prop;

  assign gen[0]  = x_i & y_i;
  assign prop[0] = x_i ^ y_i;

  for (genvar l = 0; l < IDX; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= D) begin : g_op
        assign gen[l+1][i]  = gen[l][i] | (prop[l][i] & gen[l][i-D]);
        assign prop[l+1][i] = prop[l][i] & prop[l][i-D];
      end else begin : g_pass
        assign gen[l+1][i]  = gen[l][i];
        assign prop[l+1][i] = prop[l][i];
      end
    end
  end

  // gen[IDX][i] is the carry out of bit i.
  assign sum_o = prop[0] ^ {gen[IDX][W-2:0], 1'b0};

endmodule

// File: rtl/booth_mult_pipe.sv
// Pipelined unsigned radix-4 Booth multiplier with valid/ready handshakes.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake; a, b are the unsigned operands
//   out_valid, out_ready  output handshake; p = a*b, p_zero = (p == 0)
// Stages: S1 operands, S2 compacted Booth rows, S3 reduced + summed product.
// The whole pipe advances together (global stall), so in_ready only looks
// at the last valid bit and out_ready.
module booth_mult_pipe
  import booth_mult_pkg::*;
#(
  parameter int  WIDTH = 7,
  localparam int NPP   = npp(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     p,
  output logic                   p_zero
);

  localparam int PROD_W  = prod_w(WIDTH);
  localparam int KSA_IDX = ksa_idx(WIDTH);
  localparam int SUM_W   = 1 << KSA_IDX;
  localparam int ROW_W   = WIDTH + 2;
  localparam int BX_W    = 2 * NPP + 1;
  localparam int NROWS   = NPP + 2;
  localparam int NLVL    = csa_levels(NROWS);

  // Each row is stored as {~neg, pp}, i.e. biased by +2^(WIDTH+1) at its
  // weight instead of being sign-extended. This constant removes the sum of
  // all those biases (modulo the adder width).
  function automatic logic [SUM_W-1:0] sext_corr();
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NPP; i++) begin
      acc = acc + ({{(SUM_W-1){1'b0}}, 1'b1} << (WIDTH + 1 + 2 * i));
    end
    return (~acc) + {{(SUM_W-1){1'b0}}, 1'b1};
  endfunction

  localparam logic [SUM_W-1:0] SEXT_CORR = sext_corr();

  logic advance;

  logic v1_q, v2_q, v3_q;

  logic [WIDTH-1:0] a_q, b_q;
  logic [BX_W-1:0]  bx;
  logic [WIDTH:0]   pp [NPP];
  logic [NPP-1:0]   neg;
  logic [ROW_W-1:0] row_d [NPP];
  logic [ROW_W-1:0] row_q [NPP];
  logic [NPP-1:0]   neg_q;

  logic [SUM_W-1:0] neg_row;
  logic [SUM_W-1:0] wt [NLVL+1][NROWS];
  logic [SUM_W-1:0] sum;

  logic [PROD_W-1:0] p_d, p_q;
  logic              p_zero_d, p_zero_q;

  assign advance  = !v3_q || out_ready;
  assign in_ready = advance;

  // Valid bits shift with their data; an idle input cycle becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (advance) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // S1: operands
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Multiplier with b[-1] = 0 below and zero-extension above, so the top
  // window never yields a negative digit.
  assign bx = {{(BX_W-WIDTH-1){1'b0}}, b_q, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_pp_gen #(
      .WIDTH(WIDTH)
    ) u_pp (
      .win_i (bx[2*i+2:2*i]),
      .a_i   (a_q),
      .pp_o  (pp[i]),
      .neg_o (neg[i])
    );
    assign row_d[i] = {~neg[i], pp[i]};
  end

  // S2: compacted partial products and their negate bits
  always_ff @(posedge clk) begin
    if (advance && v1_q) begin
      row_q <= row_d;
      neg_q <= neg;
    end
  end

  // Negate bits land at the LSB weight of their own row.
  for (genvar j = 0; j < SUM_W; j++) begin : g_neg
    if ((j % 2 == 0) && (j / 2 < NPP)) begin : g_set
      assign neg_row[j] = neg_q[j/2];
    end else begin : g_clr
      assign neg_row[j] = 1'b0;
    end
  end

  // Level 0 of the reduction tree: NPP weighted rows, negate row, bias fix.
  for (genvar i = 0; i < NPP; i++) begin : g_rows
    assign wt[0][i] = {{(SUM_W-ROW_W){1'b0}}, row_q[i]} << (2 * i);
  end
  assign wt[0][NPP]   = neg_row;
  assign wt[0][NPP+1] = SEXT_CORR;

  // Wallace reduction: per level, full groups of three rows go through a
  // 3:2 compressor, leftovers pass straight through. Everything is modulo
  // 2^SUM_W; the true product fits in PROD_W bits so the wrap is harmless.
  for (genvar l = 0; l < NLVL; l++) begin : g_wt
    localparam int N_IN  = csa_rows_at(NROWS, l);
    localparam int N_GRP = N_IN / 3;
    for (genvar j = 0; j < NROWS; j++) begin : g_row
      if (j < 2 * N_GRP) begin : g_csa
        localparam int B = 3 * (j / 2);
        if (j % 2 == 0) begin : g_s
          assign wt[l+1][j] = wt[l][B] ^ wt[l][B+1] ^ wt[l][B+2];
        end else begin : g_c
          assign wt[l+1][j] = ((wt[l][B] & wt[l][B+1]) |
                               (wt[l][B] & wt[l][B+2]) |
                               (wt[l][B+1] & wt[l][B+2])) << 1;
        end
      end else if (j < N_IN - N_GRP) begin : g_pass
        assign wt[l+1][j] = wt[l][3*N_GRP + j - 2*N_GRP];
      end else begin : g_none
        assign wt[l+1][j] = '0;
      end
    end
  end

  for (genvar j = 0; j < NROWS; j++) begin : g_l0_unused
    if (j >= NROWS) begin : g_never
      assign wt[0][j] = '0;
    end
  end

  ksa_adder #(
    .IDX(KSA_IDX)
  ) u_ksa (
    .x_i   (wt[NLVL][0]),
    .y_i   (wt[NLVL][1]),
    .sum_o (sum)
  );

  assign p_d      = sum[PROD_W-1:0];
  assign p_zero_d = (p_d == '0);

  // S3: result. Only real items update it, so p holds across bubbles and
  // stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= '0;
      p_zero_q <= 1'b0;
    end else if (advance && v2_q) begin
      p_q      <= p_d;
      p_zero_q <= p_zero_d;
    end
  end

  assign out_valid = v3_q;
  assign p         = p_q;
  assign p_zero    = p_zero_q;

endmodule

// File: tb/tb_booth_mult_pipe.sv
module tb_booth_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // WIDTH=7 instance: full handshake testing
  logic        iv = 1'b0, ordy = 1'b1;
  logic        ir, ov, pz7;
  logic [6:0]  a7 = '0, b7 = '0;
  logic [13:0] p7;

  // WIDTH=11 and WIDTH=8 instances: streaming against reference a*b
  logic        iv11 = 1'b0, ir11, ov11, pz11;
  logic [10:0] a11 = '0, b11 = '0;
  logic [21:0] p11;
  logic        iv8 = 1'b0, ir8, ov8, pz8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  booth_mult_pipe #(.WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a7), .b(b7),
    .out_valid(ov), .out_ready(ordy), .p(p7), .p_zero(pz7));

  booth_mult_pipe #(.WIDTH(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv11), .in_ready(ir11), .a(a11), .b(b11),
    .out_valid(ov11), .out_ready(1'b1), .p(p11), .p_zero(pz11));

  booth_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(1'b1), .p(p8), .p_zero(pz8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for the WIDTH=7 instance: accepted products in order,
  // with accept cycle and stall count so latency can be derived.
  logic [63:0] q7 [$];
  int          qc [$];
  int          qs [$];
  int          stalls = 0;
  int          out7_cnt = 0;
  logic        held_v = 1'b0;
  logic [13:0] held_p;
  logic        held_z;
  logic [63:0] e7;
  int          ac, sc;

  always @(negedge clk) begin
    if (!rst_n) begin
      q7.delete(); qc.delete(); qs.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", ov, 1'b1);
        check("hold_p", p7, held_p);
        check("hold_zero", pz7, held_z);
      end
      check("in_ready_rule", ir, !ov || ordy);
      if (ov && ordy) begin
        check("out_expected", q7.size() > 0, 1'b1);
        if (q7.size() > 0) begin
          e7 = q7.pop_front();
          ac = qc.pop_front();
          sc = qs.pop_front();
          check("p", p7, e7);
          check("p_zero", pz7, e7 == 0);
          check("latency", cyc - ac - (stalls - sc), 3);
          out7_cnt++;
        end
      end
      held_v = ov && !ordy;
      held_p = p7;
      held_z = pz7;
      if (iv && ir) begin
        q7.push_back(64'(a7) * 64'(b7));
        qc.push_back(cyc);
        qs.push_back(stalls);
      end
      if (!ir) stalls++;
    end
  end

  logic [63:0] q11 [$];
  logic [63:0] q8 [$];
  int          n11 = 0, n8 = 0;
  logic [63:0] e11, e8;

  always @(negedge clk) begin
    if (!rst_n) begin
      q11.delete();
      q8.delete();
    end else begin
      if (ov11) begin
        check("w11_expected", q11.size() > 0, 1'b1);
        if (q11.size() > 0) begin
          e11 = q11.pop_front();
          check("w11_p", p11, e11);
          check("w11_zero", pz11, e11 == 0);
          if (n11 == 0) check("w11_pin_2047sq", p11, 64'd4190209);
          if (n11 == 1) check("w11_pin_1024x3", p11, 64'd3072);
          n11++;
        end
      end
      if (iv11 && ir11) q11.push_back(64'(a11) * 64'(b11));
      if (ov8) begin
        check("w8_expected", q8.size() > 0, 1'b1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          check("w8_p", p8, e8);
          check("w8_zero", pz8, e8 == 0);
          if (n8 == 0) check("w8_pin_255sq", p8, 64'd65025);
          n8++;
        end
      end
      if (iv8 && ir8) q8.push_back(64'(a8) * 64'(b8));
    end
  end

  // All drive tasks start and end just after a rising edge.
  task automatic send(input logic [6:0] x, input logic [6:0] y, output int acc);
    iv = 1'b1; a7 = x; b7 = y;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ir) begin
        acc = cyc;
        break;
      end
    end
    check("send_accepted", ir, 1'b1);
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic wait_out(output logic [13:0] pv, output logic zv, output int oc);
    oc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ov && ordy) begin
        oc = cyc;
        break;
      end
    end
    check("out_seen", ov && ordy, 1'b1);
    pv = p7;
    zv = pz7;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0, c1, c2, o0, o1, o2, d0, d1;
  logic [13:0] r0, r1, r2;
  logic z0, z1, z2;
  int cnt_before;

  initial begin
    // reset state
    #3;
    check("rst_out_valid", ov, 1'b0);
    check("rst_p", p7, 0);
    check("rst_p_zero", pz7, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", ir, 1'b1);

    // back-to-back, no stall
    send(7'd3, 7'd5, c0);
    send(7'd127, 7'd127, c1);
    send(7'd64, 7'd2, c2);
    wait_out(r0, z0, o0);
    wait_out(r1, z1, o1);
    wait_out(r2, z2, o2);
    check("t1_p0", r0, 64'd15);
    check("t1_p1", r1, 64'd16129);
    check("t1_p2", r2, 64'd128);
    check("t1_first_latency", o0 - c0, 3);
    check("t1_consec1", o1 - o0, 1);
    check("t1_consec2", o2 - o1, 1);
    idle(3);

    // zero operands
    send(7'd0, 7'd99, c0);
    send(7'd99, 7'd0, c1);
    send(7'd1, 7'd1, c2);
    wait_out(r0, z0, o0);
    wait_out(r1, z1, o1);
    wait_out(r2, z2, o2);
    check("t2_p0", r0, 0);
    check("t2_z0", z0, 1'b1);
    check("t2_p1", r1, 0);
    check("t2_z1", z1, 1'b1);
    check("t2_p2", r2, 64'd1);
    check("t2_z2", z2, 1'b0);
    idle(3);

    // stall with 6 items streaming
    cnt_before = out7_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(7'(10 + 13 * i), 7'(3 + 19 * i), d0);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (ov) break;
        end
        check("t3_ov_seen", ov, 1'b1);
        @(posedge clk); #1;
        ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("t3_stall_in_ready", ir, 1'b0);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
      end
    join
    idle(10);
    check("t3_all_out", out7_cnt - cnt_before, 6);

    // in_valid gap pattern 1,0,1
    send(7'd5, 7'd6, c0);
    idle(1);
    send(7'd7, 7'd8, c1);
    check("t4_gap", c1 - c0, 2);
    @(negedge clk); check("t4_ov0", ov, 1'b1); check("t4_p0", p7, 64'd30);
    @(negedge clk); check("t4_ov1", ov, 1'b0);
    @(negedge clk); check("t4_ov2", ov, 1'b1); check("t4_p2", p7, 64'd56);
    @(posedge clk); #1;
    idle(3);

    // reset with 3 items in flight
    send(7'd11, 7'd12, d0);
    send(7'd13, 7'd14, d0);
    send(7'd15, 7'd16, d0);
    rst_n = 1'b0;
    #1;
    check("t5_async_ov", ov, 1'b0);
    check("t5_async_p", p7, 0);
    check("t5_async_z", pz7, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_no_stale", ov, 1'b0);
    end
    check("t5_p_after", p7, 0);
    @(posedge clk); #1;
    send(7'd9, 7'd9, c0);
    wait_out(r0, z0, o0);
    check("t5_first_p", r0, 64'd81);
    check("t5_first_lat", o0 - c0, 3);
    idle(3);

    // WIDTH=11 and WIDTH=8 streams
    iv11 = 1'b1; a11 = 11'd2047; b11 = 11'd2047;
    iv8  = 1'b1; a8  = 8'd255;   b8  = 8'd255;
    @(posedge clk); #1;
    a11 = 11'd1024; b11 = 11'd3;
    a8  = 8'd128;   b8  = 8'd2;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      a11 = 11'($urandom_range(0, 2047));
      b11 = 11'($urandom_range(0, 2047));
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    iv11 = 1'b0;
    iv8  = 1'b0;
    idle(10);
    check("w11_count", n11, 1002);
    check("w8_count", n8, 1002);
    check("w7_drained", q7.size(), 0);
    check("w11_drained", q11.size(), 0);
    check("w8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/booth_mult_pipe.md
Name: booth_mult_pipe

Overview:
- Parametrised, pipelined unsigned radix-4 Booth multiplier with valid/ready handshakes on input and output.
- Successor to the fixed 7x7 combinational multiplier, for use in the posit FMAU mantissa datapath at any fraction width.
- Internals:
  - Booth partial-product generation with sign-extension compaction.
  - Carry-save (Wallace) reduction.
  - Final Kogge-Stone add.
  - Registers between these sections.
- Accepts one operand pair per cycle when not stalled.

Parameters:
- WIDTH, 7, unsigned operand width in bits; legal range 4..32.
- NPP, WIDTH/2+1, number of Booth partial products. Derived; never overridden.

Ports:
- clk        input   1          rising-edge clock
- rst_n      input   1          asynchronous active-low reset
- in_valid   input   1          operand pair present on a, b
- in_ready   output  1          block can accept; transfer when in_valid && in_ready
- a          input   WIDTH      multiplicand, unsigned
- b          input   WIDTH      multiplier, unsigned
- out_valid  output  1          product present on p
- out_ready  input   1          downstream accepts; transfer when out_valid && out_ready
- p          output  2*WIDTH    unsigned product a*b
- p_zero     output  1          high when p == 0; qualified by out_valid

Behaviour:
- Reset and clocking:
  - Single clock. Reset is asynchronous, active-low.
  - Reset clears all stage valid bits v1, v2, v3.
  - Reset values: out_valid=0, p=0, p_zero=0. in_ready=1 one combinational settle after reset.
- Pipeline, three register stages:
  - S1: registers a, b.
  - S2: registers NPP Booth partial products after sign-extension compaction.
    - Recoding window i = b[2i+1:2i-1], with b[-1]=0 and zero-extension above the MSB. Zero-extension guarantees the last digit is non-negative.
  - S3: registers the CSA-reduced pair summed by the KSA. S3 drives p and p_zero.
- Latency: exactly 3 clk edges from an accepted input to out_valid=1 when there is no stall.
- Stall rule:
  - advance = !v3 || out_ready; in_ready = advance.
  - All stages load together when advance=1 and hold when advance=0. This is a global stall; bubbles are not collapsed.
  - The valid bit for each stage is shifted along with its data.
  - An invalid in_valid cycle with advance=1 inserts a bubble (v1 loads 0).
- Data stability: p and p_zero stay stable while out_valid && !out_ready.
- Throughput: one result per cycle when out_ready is held high.
- Combinational paths:
  - No combinational path from a, b or in_valid to any output.
  - in_ready depends combinationally only on v3 and out_ready.
- Simultaneous handshakes:
  - With out_valid && out_ready && in_valid in the same cycle, both transfers occur.
  - The pipeline shifts and no data is lost or duplicated.
- Arithmetic:
  - p equals the full 2*WIDTH-bit product.
  - The internal sum width is rounded up to a power of two for the KSA; upper bits are discarded and are guaranteed zero.
- Data registers: do not need reset; only valid bits and p/p_zero are reset.
- Reset mid-operation: in-flight results are discarded. The first out_valid after reset release belongs to the first input accepted after release.
- Odd/even WIDTH: both supported. NPP=floor(WIDTH/2)+1 covers the top digit.

Decomposition:
- Package booth_mult_pkg:
  - Function npp(width).
  - Function ksa_idx(width), defined as ceil(log2(2*width)).
  - localparam PROD_W = 2*WIDTH.
  - Booth digit enum: ZERO, P1, P2, M1, M2.
- Sub-module booth_pp_gen (WIDTH):
  - Inputs: 3-bit window and multiplicand.
  - Outputs: WIDTH+1-bit magnitude-selected, inverted partial product and negate bit.
  - Instantiated NPP times in a generate loop.
- Existing pieces reused: Wallace reduction (generic CSA loop written here) and the existing KSA module.

Test Plan:
- Reset, then operand pairs: (3,5), (127,127), (64,2) back-to-back with out_ready=1 → p=15, 16129, 128 on three consecutive cycles. First result 3 cycles after the first accept.
- (0,99) and (99,0) → p=0, p_zero=1. Then (1,1) → p=1, p_zero=0.
- Stream 6 inputs; hold out_ready=0 for 4 cycles once out_valid=1 → p held constant and in_ready=0 while stalled. On release, all 6 products appear in order with none lost.
- Inject in_valid gaps (1,0,1) → out_valid shows the same pattern delayed by 3 cycles.
- Assert rst_n=0 for 1 cycle while 3 items are in flight → out_valid=0 and p=0 immediately (asynchronous). No stale product appears after release.
- WIDTH=11 instance with (2047,2047), (1024,3) and 1000 random pairs → p=4190209, 3072, and a match against the reference a*b. Repeat with WIDTH=8, including (255,255) → p=65025.
